// File: rtl/prgm_pkg.sv
// Shared state type and geometry constants for the program-memory controller.
package prgm_pkg;

   localparam int unsigned ADDR_W     = 6;
   localparam int unsigned DATA_W     = 8;
   localparam int unsigned RD_CYC     = 2;
   localparam int unsigned WR_CYC     = 3;
   localparam int unsigned PRGM_DEPTH = 64;

   typedef enum logic [2:0] {
      StIdle,
      StErase,
      StWrite,
      StRead,
      StAck
   } prgm_state_e;

endpackage

// File: rtl/prgm_ctrl.sv
// Sequencer/arbiter for the 64x8 program memory: loader writes, fetch reads and
// whole-memory erase, each holding address/mode for the memory's multi-cycle access.
module prgm_ctrl
   import prgm_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              erase_req,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_adrs,
   output logic              f_ack,
   output logic [DATA_W-1:0] f_data,
   output logic [ADDR_W-1:0] m_adrs,
   output logic              m_mode,
   output logic [DATA_W-1:0] m_data,
   output logic              m_erase,
   input  logic [DATA_W-1:0] m_out,
   output logic [ADDR_W:0]   prog_len,
   output logic              prog_loaded,
   output logic              busy
);

   prgm_state_e       state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] m_adrs_q, m_adrs_d;
   logic [DATA_W-1:0] m_data_q, m_data_d;
   logic              m_mode_q, m_mode_d;
   logic              m_erase_q, m_erase_d;
   logic [DATA_W-1:0] f_data_q, f_data_d;
   logic [ADDR_W:0]   prog_len_q, prog_len_d;
   logic              prog_loaded_q, prog_loaded_d;
   logic              last_q, last_d;
   logic              erase_pend_q, erase_pend_d;
   logic              erase_any;
   logic [ADDR_W:0]   len_inc;

   assign erase_any = erase_req | erase_pend_q;
   assign len_inc   = prog_len_q + 7'd1;

   assign ld_ready    = (state_q == StIdle) && !erase_req && !erase_pend_q &&
                        !prog_loaded_q && !reset;
   assign f_ack       = (state_q == StAck);
   assign busy        = (state_q != StIdle);
   assign f_data      = f_data_q;
   assign m_adrs      = m_adrs_q;
   assign m_mode      = m_mode_q;
   assign m_data      = m_data_q;
   assign m_erase     = m_erase_q;
   assign prog_len    = prog_len_q;
   assign prog_loaded = prog_loaded_q;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      m_adrs_d      = m_adrs_q;
      m_data_d      = m_data_q;
      m_mode_d      = 1'b0;
      m_erase_d     = 1'b0;
      f_data_d      = f_data_q;
      prog_len_d    = prog_len_q;
      prog_loaded_d = prog_loaded_q;
      last_d        = last_q;
      erase_pend_d  = erase_pend_q;

      case (state_q)
         StIdle: begin
            if (erase_any) begin
               state_d   = StErase;
               m_erase_d = 1'b1;
            end else if (ld_valid && ld_ready) begin
               state_d  = StWrite;
               m_adrs_d = prog_len_q[ADDR_W-1:0];
               m_data_d = ld_data;
               m_mode_d = 1'b1;
               cnt_d    = 2'd0;
               last_d   = ld_last;
            end else if (f_req && prog_loaded_q) begin
               state_d  = StRead;
               m_adrs_d = f_adrs;
               cnt_d    = 2'd0;
            end
         end
         StErase: begin
            state_d       = StIdle;
            prog_len_d    = '0;
            prog_loaded_d = 1'b0;
         end
         StWrite: begin
            if (cnt_q == 2'(WR_CYC - 1)) begin
               prog_len_d    = len_inc;
               prog_loaded_d = prog_loaded_q | last_q | (len_inc == 7'(PRGM_DEPTH));
               // A pending erase goes straight out without an idle bubble.
               if (erase_any) begin
                  state_d   = StErase;
                  m_erase_d = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               cnt_d    = cnt_q + 2'd1;
               m_mode_d = 1'b1;
            end
         end
         StRead: begin
            // Address has now been held for RD_CYC edges; m_out is valid.
            if (cnt_q == 2'(RD_CYC)) begin
               f_data_d = m_out;
               state_d  = StAck;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         StAck: begin
            if (erase_any) begin
               state_d   = StErase;
               m_erase_d = 1'b1;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (state_d == StErase || state_q == StErase) begin
         erase_pend_d = 1'b0;
      end else if (state_q != StIdle && erase_req) begin
         erase_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         m_adrs_q      <= '0;
         m_data_q      <= '0;
         m_mode_q      <= 1'b0;
         m_erase_q     <= 1'b0;
         f_data_q      <= '0;
         prog_len_q    <= '0;
         prog_loaded_q <= 1'b0;
         last_q        <= 1'b0;
         erase_pend_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         m_adrs_q      <= m_adrs_d;
         m_data_q      <= m_data_d;
         m_mode_q      <= m_mode_d;
         m_erase_q     <= m_erase_d;
         f_data_q      <= f_data_d;
         prog_len_q    <= prog_len_d;
         prog_loaded_q <= prog_loaded_d;
         last_q        <= last_d;
         erase_pend_q  <= erase_pend_d;
      end
   end

endmodule

// File: tb/tb_prgm_ctrl.sv
// Self-checking bench for prgm_ctrl with a behavioural 64x8 memory that only commits
// writes held for 3 edges and only returns reads held for 2 edges.
module tb_prgm_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       erase_req = 1'b0;
   logic       ld_valid = 1'b0;
   logic [7:0] ld_data = 8'h00;
   logic       ld_last = 1'b0;
   logic       ld_ready;
   logic       f_req = 1'b0;
   logic [5:0] f_adrs = 6'd0;
   logic       f_ack;
   logic [7:0] f_data;
   logic [5:0] m_adrs;
   logic       m_mode;
   logic [7:0] m_data;
   logic       m_erase;
   logic [7:0] m_out = 8'h00;
   logic [6:0] prog_len;
   logic       prog_loaded;
   logic       busy;

   int checks = 0;
   int failures = 0;

   prgm_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .erase_req  (erase_req),
      .ld_valid   (ld_valid),
      .ld_data    (ld_data),
      .ld_last    (ld_last),
      .ld_ready   (ld_ready),
      .f_req      (f_req),
      .f_adrs     (f_adrs),
      .f_ack      (f_ack),
      .f_data     (f_data),
      .m_adrs     (m_adrs),
      .m_mode     (m_mode),
      .m_data     (m_data),
      .m_erase    (m_erase),
      .m_out      (m_out),
      .prog_len   (prog_len),
      .prog_loaded(prog_loaded),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Program memory stand-in: enforces the hold rules so short accesses are visible.
   logic [7:0] mem [64];
   logic [5:0] wr_adrs_p = 6'd0;
   logic [5:0] rd_adrs_p = 6'd0;
   logic [7:0] wr_data_p = 8'h00;
   int         wr_hold = 0;
   int         rd_hold = 0;

   initial for (int i = 0; i < 64; i++) mem[i] = 8'h00;

   always @(posedge clk) begin
      if (m_erase) begin
         for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
         wr_hold <= 0;
         rd_hold <= 0;
      end else if (m_mode) begin
         rd_hold <= 0;
         if (wr_hold > 0 && m_adrs == wr_adrs_p && m_data == wr_data_p) begin
            wr_hold <= wr_hold + 1;
            if (wr_hold + 1 == 3) mem[m_adrs] <= m_data;
         end else begin
            wr_hold <= 1;
         end
         wr_adrs_p <= m_adrs;
         wr_data_p <= m_data;
      end else begin
         wr_hold <= 0;
         if (rd_hold > 0 && m_adrs == rd_adrs_p) begin
            rd_hold <= rd_hold + 1;
            if (rd_hold + 1 >= 2) m_out <= mem[m_adrs];
         end else begin
            rd_hold <= 1;
         end
         rd_adrs_p <= m_adrs;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // All tasks start and end just after a falling edge.
   task automatic do_load(input logic [7:0] d, input bit last, input bit accept,
                          input logic [5:0] adrs, input logic [6:0] len_after,
                          input bit loaded_after);
      logic [3:0] mb;
      int         hi;
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = last;
      #1;
      if (!accept) begin
         hi = 0;
         repeat (6) begin
            @(negedge clk);
            if (m_mode || ld_ready) hi++;
         end
         ld_valid = 1'b0;
         ld_last  = 1'b0;
         check("stall_beat_taken", 32'(hi), 32'd0);
         check("stall_len", 32'(prog_len), 32'(len_after));
      end else begin
         check("ld_ready_idle", 32'(ld_ready), 32'd1);
         @(negedge clk);
         ld_valid = 1'b0;
         ld_last  = 1'b0;
         mb[0] = m_mode;
         check("wr_adrs", 32'(m_adrs), 32'(adrs));
         check("wr_data", 32'(m_data), 32'(d));
         for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            mb[i] = m_mode;
         end
         check("wr_mode_cycles", 32'(mb), 32'b0111);
         check("wr_len", 32'(prog_len), 32'(len_after));
         check("wr_loaded", 32'(prog_loaded), 32'(loaded_after));
         check("wr_ld_ready_after", 32'(ld_ready), 32'(!loaded_after));
      end
   endtask

   task automatic do_fetch(input logic [5:0] a, input bit exp_ack, input logic [7:0] exp_d);
      int k;
      int acks;
      f_req  = 1'b1;
      f_adrs = a;
      if (exp_ack) begin
         @(negedge clk);
         f_req = 1'b0;
         k = 1;
         while (!f_ack && k < 10) begin
            @(negedge clk);
            k++;
         end
         check("fetch_latency", 32'(k), 32'd4);
         check("fetch_data", 32'(f_data), 32'(exp_d));
         @(negedge clk);
         check("fetch_ack_pulse", 32'(f_ack), 32'd0);
         check("fetch_data_hold", 32'(f_data), 32'(exp_d));
      end else begin
         acks = 0;
         repeat (8) begin
            @(negedge clk);
            if (f_ack) acks++;
         end
         f_req = 1'b0;
         check("fetch_unloaded_ack", 32'(acks), 32'd0);
      end
   endtask

   task automatic do_erase();
      erase_req = 1'b1;
      #1;
      check("erase_ld_ready", 32'(ld_ready), 32'd0);
      @(negedge clk);
      erase_req = 1'b0;
      check("erase_pulse_on", 32'(m_erase), 32'd1);
      check("erase_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("erase_pulse_off", 32'(m_erase), 32'd0);
      check("erase_len", 32'(prog_len), 32'd0);
      check("erase_loaded", 32'(prog_loaded), 32'd0);
   endtask

   typedef enum int {OpLoad, OpFetch, OpErase} op_e;
   typedef struct {
      op_e        op;
      logic [7:0] data;
      bit         last;
      logic [5:0] adrs;
      bit         ok;
      logic [7:0] exp_data;
      logic [6:0] exp_len;
      bit         exp_loaded;
   } vec_t;

   vec_t       vecs [10];
   logic [7:0] exp_mem [64];
   int         exp_len;
   bit         exp_loaded;
   logic [4:0] mode_seq;
   logic [4:0] erase_seq;
   int         acks;

   initial begin
      // op, data, last, adrs, ok(accept/ack), exp_data, exp_len, exp_loaded
      vecs[0] = '{OpLoad,  8'hA5, 1'b0, 6'd0, 1'b1, 8'h00, 7'd1, 1'b0};
      vecs[1] = '{OpLoad,  8'h3C, 1'b0, 6'd1, 1'b1, 8'h00, 7'd2, 1'b0};
      vecs[2] = '{OpLoad,  8'h7E, 1'b1, 6'd2, 1'b1, 8'h00, 7'd3, 1'b1};
      vecs[3] = '{OpFetch, 8'h00, 1'b0, 6'd1, 1'b1, 8'h3C, 7'd3, 1'b1};
      vecs[4] = '{OpFetch, 8'h00, 1'b0, 6'd5, 1'b1, 8'h00, 7'd3, 1'b1};
      vecs[5] = '{OpFetch, 8'h00, 1'b0, 6'd2, 1'b1, 8'h7E, 7'd3, 1'b1};
      vecs[6] = '{OpFetch, 8'h00, 1'b0, 6'd0, 1'b1, 8'hA5, 7'd3, 1'b1};
      vecs[7] = '{OpLoad,  8'h11, 1'b0, 6'd3, 1'b0, 8'h00, 7'd3, 1'b1};
      vecs[8] = '{OpErase, 8'h00, 1'b0, 6'd0, 1'b0, 8'h00, 7'd0, 1'b0};
      vecs[9] = '{OpFetch, 8'h00, 1'b0, 6'd1, 1'b0, 8'h00, 7'd0, 1'b0};

      // Reset values, including the reset term of ld_ready.
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_m_mode", 32'(m_mode), 32'd0);
      check("rst_m_erase", 32'(m_erase), 32'd0);
      check("rst_f_ack", 32'(f_ack), 32'd0);
      check("rst_len", 32'(prog_len), 32'd0);
      check("rst_loaded", 32'(prog_loaded), 32'd0);
      check("rst_m_adrs", 32'(m_adrs), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_f_data", 32'(f_data), 32'd0);
      check("rst_ld_ready", 32'(ld_ready), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         case (vecs[i].op)
            OpLoad:  do_load(vecs[i].data, vecs[i].last, vecs[i].ok, vecs[i].adrs,
                             vecs[i].exp_len, vecs[i].exp_loaded);
            OpFetch: do_fetch(vecs[i].adrs, vecs[i].ok, vecs[i].exp_data);
            default: do_erase();
         endcase
      end

      // Fill the whole memory without ld_last.
      for (int i = 0; i < 64; i++) begin
         do_load(8'(i), 1'b0, 1'b1, 6'(i), 7'(i + 1), i == 63);
      end
      do_load(8'h99, 1'b0, 1'b0, 6'd0, 7'd64, 1'b1);
      do_fetch(6'd63, 1'b1, 8'h3F);
      do_fetch(6'd0, 1'b1, 8'h00);

      // Erase and a loader beat in the same idle cycle: erase wins, byte lands at 0.
      erase_req = 1'b1;
      ld_valid  = 1'b1;
      ld_data   = 8'h55;
      #1;
      check("ee_ld_ready", 32'(ld_ready), 32'd0);
      @(negedge clk);
      erase_req = 1'b0;
      check("ee_erase_on", 32'(m_erase), 32'd1);
      check("ee_ld_ready_erase", 32'(ld_ready), 32'd0);
      @(negedge clk);
      check("ee_erase_off", 32'(m_erase), 32'd0);
      check("ee_ld_ready_back", 32'(ld_ready), 32'd1);
      @(negedge clk);
      ld_valid = 1'b0;
      check("ee_mode", 32'(m_mode), 32'd1);
      check("ee_adrs", 32'(m_adrs), 32'd0);
      check("ee_data", 32'(m_data), 32'h55);
      repeat (3) @(negedge clk);
      check("ee_mode_end", 32'(m_mode), 32'd0);
      check("ee_len", 32'(prog_len), 32'd1);

      // Erase pulse during a write: write keeps its 3 cycles, erase follows at once.
      ld_valid = 1'b1;
      ld_data  = 8'hC3;
      ld_last  = 1'b1;
      @(negedge clk);
      ld_valid  = 1'b0;
      ld_last   = 1'b0;
      erase_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 1) erase_req = 1'b0;
         mode_seq[i]  = m_mode;
         erase_seq[i] = m_erase;
         if (i < 4) @(negedge clk);
      end
      check("we_mode_seq", 32'(mode_seq), 32'b00111);
      check("we_erase_seq", 32'(erase_seq), 32'b01000);
      check("we_loaded", 32'(prog_loaded), 32'd0);
      check("we_len", 32'(prog_len), 32'd0);

      // Reset during a read: no ack ever, everything back to reset values.
      do_load(8'h42, 1'b1, 1'b1, 6'd0, 7'd1, 1'b1);
      acks = 0;
      f_req  = 1'b1;
      f_adrs = 6'd0;
      @(negedge clk);
      f_req = 1'b0;
      if (f_ack) acks++;
      @(negedge clk);
      if (f_ack) acks++;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rr_mode", 32'(m_mode), 32'd0);
      check("rr_len", 32'(prog_len), 32'd0);
      check("rr_loaded", 32'(prog_loaded), 32'd0);
      check("rr_busy", 32'(busy), 32'd0);
      check("rr_f_data", 32'(f_data), 32'd0);
      repeat (8) begin
         @(negedge clk);
         if (f_ack) acks++;
      end
      check("rr_no_ack", 32'(acks), 32'd0);
      do_fetch(6'd0, 1'b0, 8'h00);

      // Randomised traffic against a transaction-level model.
      do_erase();
      for (int i = 0; i < 64; i++) exp_mem[i] = 8'h00;
      exp_len    = 0;
      exp_loaded = 1'b0;
      for (int n = 0; n < 90; n++) begin
         int         r;
         int         old_len;
         logic [7:0] d;
         bit         last;
         logic [5:0] a;
         r = $urandom_range(0, 99);
         if (r < 8) begin
            do_erase();
            for (int i = 0; i < 64; i++) exp_mem[i] = 8'h00;
            exp_len    = 0;
            exp_loaded = 1'b0;
         end else if (r < 55) begin
            d    = 8'($urandom);
            last = ($urandom_range(0, 9) == 0);
            if (!exp_loaded) begin
               old_len          = exp_len;
               exp_mem[old_len] = d;
               exp_len          = exp_len + 1;
               exp_loaded       = last || (exp_len == 64);
               do_load(d, last, 1'b1, 6'(old_len), 7'(exp_len), exp_loaded);
            end else begin
               do_load(d, last, 1'b0, 6'd0, 7'(exp_len), 1'b1);
            end
         end else begin
            a = 6'($urandom_range(0, 63));
            do_fetch(a, exp_loaded, exp_mem[a]);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
